i2c_target: RTL
===============

Name: i2c_target

Overview:
- I2C target (slave) block; the responder for the `CF_I2C_WB` master.
- Exposes a 256-byte register space through a simple synchronous register port.
- Samples filtered SCL/SDA on the system clock and drives SDA open-drain through the `*_o`/`*_oen_o` pad convention used by the master (pad `io_oeb = ~oen`).
- Used on-chip as a loopback target on a second GPIO pair, and as a bring-up/verification peer.

Parameters:
- I2C_ADDR, 7'h50, 7-bit target address matched after START.
- FILTER_LEN, 3, system-clock cycles a synchronized SCL/SDA level must be stable before the filtered value changes (1..15).

Ports:
- wb_clk_i  in  1  system clock; SCL must be ≤ wb_clk_i/16.
- wb_rst_i  in  1  reset, synchronous, active-high.
- scl_i  in  1  SCL pad input.
- sda_i  in  1  SDA pad input.
- scl_o  out  1  constant 0.
- scl_oen_o  out  1  constant 0; no clock stretching.
- sda_o  out  1  constant 0.
- sda_oen_o  out  1  1 = pull SDA low.
- reg_addr_o  out  8  register pointer.
- reg_wdata_o  out  8  write data.
- reg_wr_o  out  1  one-cycle write strobe.
- reg_rd_o  out  1  one-cycle read strobe.
- reg_rdata_i  in  8  read data, valid the cycle after reg_rd_o.
- busy_o  out  1  1 from address match until STOP or abort.

Behaviour:
- Reset values: all outputs 0; state IDLE; pointer 0; filters preset to 1.
- Wb_rst_i mid-transfer releases SDA on the next cycle.
- Input conditioning: each of scl_i/sda_i passes through a 2-flop synchronizer, then a stability counter.
  - The filtered value updates only after FILTER_LEN consecutive equal samples.
  - Edge pulses (scl_rise, scl_fall) are derived from the filtered SCL.
- Condition detection:
  - START: filtered SDA 1→0 while filtered SCL=1.
  - STOP: filtered SDA 0→1 while filtered SCL=1.
  - Both have priority over every state.
  - START (incl. repeated) → ADDR with bit counter cleared, sda_oen_o=0.
  - STOP → IDLE with sda_oen_o=0; the pointer is retained.
- Timing: SDA is sampled on scl_rise; sda_oen_o changes only on the cycle after scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first.
    - On 8th scl_rise, compare [7:1] with I2C_ADDR.
    - Match → ADDR_ACK with busy_o=1, rw=bit0.
    - Mismatch → IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
  - ADDR_ACK: drive 0 from the scl_fall after bit 8 to the next scl_fall.
    - Then rw=0 → PTR.
    - rw=1 → pulse reg_rd_o (addr=pointer), load reg_rdata_i next cycle, → RDATA.
  - PTR: shift 8 bits, load pointer on 8th scl_rise → PTR_ACK (drive 0 for one SCL), → WDATA.
  - WDATA: shift 8 bits.
    - On 8th scl_rise: reg_wdata_o=byte, reg_addr_o=pointer, reg_wr_o pulse 1 cycle; pointer+1.
    - → WDATA_ACK (drive 0 for one SCL), → WDATA.
  - RDATA: drive ~bit (oen=1 when bit=0) MSB-first, each bit set after scl_fall.
    - After the 8th bit's scl_fall, release SDA → RACK; pointer+1.
  - RACK: sample master ACK on scl_rise.
    - ACK(0): at next scl_fall pulse reg_rd_o, load next cycle → RDATA.
    - NACK(1) → IGNORE (busy_o stays 1 until STOP/START).
- Pointer: 8-bit, wraps 8'hFF→8'h00 on both reads and writes.
- Latency: register write strobe occurs FILTER_LEN+3 cycles after the raw SCL rise of bit 8. Read data must be ready within one cycle of reg_rd_o.
- Simultaneous/abort cases:
  - START mid-byte abandons the partial byte with no reg_wr_o.
  - STOP mid-read releases SDA immediately.
  - A data byte before the pointer byte cannot occur; the first write byte is always the pointer.
- Glitches shorter than FILTER_LEN cycles on either line produce no edge, START or STOP.

Decomposition:
- Package i2c_target_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, IGNORE, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK);
  - localparam BYTE_W=8;
  - SYNC_STAGES=2.
- Sub-module i2c_in_filter (sync + stability counter + rise/fall pulses), instantiated twice for SCL and SDA.

Test Plan:
- Write: START, 0xA0, 0x10, 0x5A, 0xC3, STOP → ACK on all 4 bytes; reg_wr_o at addr 0x10 data 0x5A, addr 0x11 data 0xC3; pointer ends 0x12.
- Random read: START, 0xA0, 0x20, Sr, 0xA1, read 3 bytes (ACK, ACK, NACK), STOP; model reg[n]=n^0xFF → bytes 0xDF, 0xDE, 0xDD; SDA released after NACK.
- Address mismatch: START, 0xA2, 0x00, STOP → SDA never driven, no reg strobes, busy_o stays 0.
- Wrap: write pointer 0xFF, data 0x11, 0x22 → writes to 0xFF then 0x00.
- Glitch/abort: 2-cycle SDA pulse while SCL high (FILTER_LEN=3) → no START/STOP; START after 4 data bits of a write byte → no reg_wr_o, state ADDR.
- Reset mid-read while driving 0 → sda_oen_o=0 and busy_o=0 the cycle after wb_rst_i; next transaction proceeds normally.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_pkg;
    localparam int BYTE_W      = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        IGNORE,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK
    } state_t;
endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioning: synchronizer, stability filter and edge pulses.
module i2c_in_filter
    import i2c_target_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             cnt_q;
    logic                   filt_q;
    logic                   filt_d1_q;

    // Counter tracks consecutive synchronized samples that differ from the filtered level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            cnt_q     <= '0;
            filt_q    <= 1'b1;
            filt_d1_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
            filt_d1_q <= filt_q;
            if (sync_q[SYNC_STAGES-1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
                filt_q <= sync_q[SYNC_STAGES-1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign dout = filt_q;
    assign rise = filt_q & ~filt_d1_q;
    assign fall = ~filt_q & filt_d1_q;
endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a 256-byte register space through a synchronous register port.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR   = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              scl_o,
    output logic              scl_oen_o,
    output logic              sda_o,
    output logic              sda_oen_o,
    output logic [BYTE_W-1:0] reg_addr_o,
    output logic [BYTE_W-1:0] reg_wdata_o,
    output logic              reg_wr_o,
    output logic              reg_rd_o,
    input  logic [BYTE_W-1:0] reg_rdata_i,
    output logic              busy_o
);
    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk (wb_clk_i), .rst (wb_rst_i), .din (scl_i),
        .dout(scl_f), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk (wb_clk_i), .rst (wb_rst_i), .din (sda_i),
        .dout(sda_f), .rise(sda_rise), .fall(sda_fall)
    );

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [BYTE_W-1:0] ptr_q, ptr_d;
    logic [BYTE_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              phase_q, phase_d;
    logic              oen_q, oen_d;
    logic              busy_q, busy_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              load_q;

    logic              start_det, stop_det, last_bit;
    logic [BYTE_W-1:0] shift_in;

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;
    assign last_bit  = (bit_cnt_q == 4'(BYTE_W - 1));
    assign shift_in  = {shreg_q[BYTE_W-2:0], sda_f};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ptr_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            oen_q     <= 1'b0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
            oen_q     <= oen_d;
            busy_q    <= busy_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            load_q    <= rd_q;
        end
    end

    // phase_q marks the second half of an ACK slot, or a sampled master ACK in RACK.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        phase_d   = phase_q;
        oen_d     = oen_q;
        busy_d    = busy_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            oen_d     = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            oen_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            if (load_q && state_q == RDATA) begin
                shreg_d   = reg_rdata_i;
                oen_d     = ~reg_rdata_i[BYTE_W-1];
                bit_cnt_d = '0;
            end
            case (state_q)
                IDLE, IGNORE: ;
                ADDR: if (scl_rise) begin
                    shreg_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        phase_d   = 1'b0;
                        if (shift_in[BYTE_W-1:1] == I2C_ADDR) begin
                            state_d = ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = shift_in[0];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        oen_d   = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        oen_d     = 1'b0;
                        phase_d   = 1'b0;
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d = RDATA;
                            rd_d    = 1'b1;
                            addr_d  = ptr_q;
                        end else begin
                            state_d = PTR;
                        end
                    end
                end
                PTR: if (scl_rise) begin
                    shreg_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (last_bit) begin
                        ptr_d     = shift_in;
                        bit_cnt_d = '0;
                        phase_d   = 1'b0;
                        state_d   = PTR_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        oen_d   = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        oen_d     = 1'b0;
                        phase_d   = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = WDATA;
                    end
                end
                WDATA: if (scl_rise) begin
                    shreg_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (last_bit) begin
                        wdata_d   = shift_in;
                        addr_d    = ptr_q;
                        wr_d      = 1'b1;
                        ptr_d     = ptr_q + 8'd1;
                        bit_cnt_d = '0;
                        phase_d   = 1'b0;
                        state_d   = WDATA_ACK;
                    end
                end
                RDATA: if (scl_fall) begin
                    if (last_bit) begin
                        oen_d   = 1'b0;
                        ptr_d   = ptr_q + 8'd1;
                        phase_d = 1'b0;
                        state_d = RACK;
                    end else begin
                        oen_d     = ~shreg_q[BYTE_W-2];
                        shreg_d   = {shreg_q[BYTE_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (sda_f) state_d = IGNORE;
                        else       phase_d = 1'b1;
                    end
                    if (scl_fall && phase_q) begin
                        rd_d    = 1'b1;
                        addr_d  = ptr_q;
                        phase_d = 1'b0;
                        state_d = RDATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign scl_o       = 1'b0;
    assign scl_oen_o   = 1'b0;
    assign sda_o       = 1'b0;
    assign sda_oen_o   = oen_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wr_o    = wr_q;
    assign reg_rd_o    = rd_q;
    assign busy_o      = busy_q;
endmodule
